top_entity: RTL and testbench

TOP_ENTITY -- requirements
Module: top_entity

---
 rtl/top_entity_pkg.sv | 13 +
 rtl/event_queue.sv | 44 ++++
 rtl/top_entity.sv | 75 +++++++
 tb/tb_top_entity.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/top_entity_pkg.sv
// Shared widths and the pipeline stage record for top_entity.
package top_entity_pkg;
  localparam int DATA_W      = 64;
  localparam int QUEUE_DEPTH = 4;
  localparam int NUM_OUTPUTS = 4;
  localparam int NUM_STAGES  = NUM_OUTPUTS + 1;
  localparam int PTR_W       = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] value;
  } stage_t;
endpackage

// File: rtl/event_queue.sv
// Event FIFO; push/pop are already-qualified operations from the caller.
module event_queue
  import top_entity_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QUEUE_DEPTH);

  logic [QUEUE_DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]                   wptr, rptr;
  logic [PTR_W:0]                     count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      // Simultaneous push/pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/top_entity.sv
// Event-paced increment chain: queue feeds S0, each later stage adds one.
module top_entity
  import top_entity_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] input_0,
  input  logic              new_input_0,
  output logic [DATA_W-1:0] output_0,
  output logic [DATA_W-1:0] output_1,
  output logic [DATA_W-1:0] output_2,
  output logic [DATA_W-1:0] output_3,
  output logic              output_0_aktv,
  output logic              output_1_aktv,
  output logic              output_2_aktv,
  output logic              output_3_aktv,
  output logic              q_push,
  output logic              q_pop,
  output logic              q_push_valid,
  output logic              q_pop_valid,
  output logic              pacing_in0,
  output logic              pacing_out0_0,
  output logic              pacing_out1_0,
  output logic              pacing_out2_0,
  output logic              pacing_out3_0
);
  logic              full, empty;
  logic [DATA_W-1:0] q_rdata;
  stage_t [NUM_STAGES-1:0] stg;

  assign q_push       = new_input_0 & en;
  assign q_pop        = en;
  assign q_pop_valid  = q_pop & ~empty;
  assign q_push_valid = q_push & (~full | q_pop_valid);

  event_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push_valid),
    .pop   (q_pop_valid),
    .wdata (input_0),
    .rdata (q_rdata),
    .full  (full),
    .empty (empty)
  );

  // Value registers only move on a valid beat so outputs hold between events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg <= '0;
    end else if (en) begin
      stg[0].valid <= q_pop_valid;
      if (q_pop_valid) stg[0].value <= q_rdata;
      for (int k = 1; k < NUM_STAGES; k++) begin
        stg[k].valid <= stg[k-1].valid;
        if (stg[k-1].valid) stg[k].value <= stg[k-1].value + DATA_W'(1);
      end
    end
  end

  assign output_0      = stg[1].value;
  assign output_1      = stg[2].value;
  assign output_2      = stg[3].value;
  assign output_3      = stg[4].value;
  assign output_0_aktv = stg[1].valid;
  assign output_1_aktv = stg[2].valid;
  assign output_2_aktv = stg[3].valid;
  assign output_3_aktv = stg[4].valid;
  assign pacing_in0    = stg[0].valid;
  assign pacing_out0_0 = stg[1].valid;
  assign pacing_out1_0 = stg[2].valid;
  assign pacing_out2_0 = stg[3].valid;
  assign pacing_out3_0 = stg[4].valid;
endmodule

// File: tb/tb_top_entity.sv
// Directed + random bench for top_entity against an event-age reference model.
module tb_top_entity;
  logic        clk = 1'b0;
  logic        rst, en, new_input_0;
  logic [63:0] input_0;
  logic [63:0] output_0, output_1, output_2, output_3;
  logic        output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv;
  logic        q_push, q_pop, q_push_valid, q_pop_valid;
  logic        pacing_in0, pacing_out0_0, pacing_out1_0, pacing_out2_0, pacing_out3_0;

  top_entity dut (
    .clk(clk), .rst(rst), .en(en), .input_0(input_0), .new_input_0(new_input_0),
    .output_0(output_0), .output_1(output_1), .output_2(output_2), .output_3(output_3),
    .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv),
    .output_2_aktv(output_2_aktv), .output_3_aktv(output_3_aktv),
    .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
    .pacing_in0(pacing_in0), .pacing_out0_0(pacing_out0_0), .pacing_out1_0(pacing_out1_0),
    .pacing_out2_0(pacing_out2_0), .pacing_out3_0(pacing_out3_0)
  );

  always #5 clk = ~clk;

  logic [63:0] outs [4];
  logic        aktv [4];
  logic        pac  [4];
  assign outs[0] = output_0;      assign outs[1] = output_1;
  assign outs[2] = output_2;      assign outs[3] = output_3;
  assign aktv[0] = output_0_aktv; assign aktv[1] = output_1_aktv;
  assign aktv[2] = output_2_aktv; assign aktv[3] = output_3_aktv;
  assign pac[0]  = pacing_out0_0; assign pac[1]  = pacing_out1_0;
  assign pac[2]  = pacing_out2_0; assign pac[3]  = pacing_out3_0;

  int n_cmp = 0;
  int n_err = 0;

  // Model: FIFO contents, plus each in-flight event's value and age in edges
  // since it was popped (age a means the event sits a edges past S0).
  logic [63:0] mq [$];
  logic [63:0] fv [$];
  int          fa [$];
  logic [63:0] exp_out [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic age_present(input int age);
    foreach (fa[i]) if (fa[i] == age) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outs(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s output_%0d", tag, k), outs[k], exp_out[k]);
      chk($sformatf("%s output_%0d_aktv", tag, k), 64'(aktv[k]), 64'(age_present(k+1)));
      chk($sformatf("%s pacing_out%0d_0", tag, k), 64'(pac[k]), 64'(age_present(k+1)));
    end
    chk($sformatf("%s pacing_in0", tag), 64'(pacing_in0), 64'(age_present(0)));
  endtask

  task automatic step(input logic nw, input logic [63:0] v, input logic e);
    logic pop, pok;
    @(negedge clk);
    new_input_0 = nw; input_0 = v; en = e;
    #1;
    pop = e && (mq.size() > 0);
    pok = e && nw && ((mq.size() < 4) || pop);
    chk("q_push", 64'(q_push), 64'(nw & e));
    chk("q_pop", 64'(q_pop), 64'(e));
    chk("q_pop_valid", 64'(q_pop_valid), 64'(pop));
    chk("q_push_valid", 64'(q_push_valid), 64'(pok));
    @(posedge clk);
    if (e) begin
      for (int i = fa.size() - 1; i >= 0; i--) begin
        fa[i]++;
        if (fa[i] > 4) begin fa.delete(i); fv.delete(i); end
      end
      if (pop) begin fv.push_back(mq.pop_front()); fa.push_back(0); end
      if (pok) mq.push_back(v);
      foreach (fa[i]) if (fa[i] >= 1) exp_out[fa[i]-1] = fv[i] + 64'(fa[i]);
    end
    #1;
    check_outs("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    new_input_0 = 1'b0;
    rst = 1'b0;
    #1;
    mq.delete(); fv.delete(); fa.delete();
    for (int k = 0; k < 4; k++) exp_out[k] = '0;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; new_input_0 = 1'b0; input_0 = '0;
    for (int k = 0; k < 4; k++) exp_out[k] = '0;
    #2;
    check_outs("init");
    chk("init q_pop_valid", 64'(q_pop_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single event: 1 -> 2,3,4,5 one cycle apart.
    step(1'b1, 64'd1, 1'b1);
    repeat (6) step(1'b0, 64'd0, 1'b1);
    chk("single output_0", output_0, 64'd2);
    chk("single output_3", output_3, 64'd5);

    // Back-to-back events 6..10.
    for (int i = 6; i <= 10; i++) step(1'b1, 64'(i), 1'b1);
    repeat (6) step(1'b0, 64'd0, 1'b1);
    chk("burst output_3 last", output_3, 64'd14);

    // Wrap at the signed maximum.
    step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    repeat (6) step(1'b0, 64'd0, 1'b1);
    chk("wrap output_0", output_0, 64'h8000_0000_0000_0000);
    chk("wrap output_1", output_1, 64'h8000_0000_0000_0001);

    // en=0 blocks pushes; then events only on enabled cycles of a toggling en.
    for (int i = 0; i < 5; i++) step(1'b1, 64'(50 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(i % 2 == 0, 64'(100 + i), i % 2 == 0);
    repeat (10) step(1'b0, 64'd0, 1'b1);

    // Reset with an event in flight, then a fresh event 3.
    step(1'b1, 64'd40, 1'b1);
    step(1'b0, 64'd0, 1'b1);
    step(1'b0, 64'd0, 1'b1);
    do_reset();
    repeat (6) step(1'b0, 64'd0, 1'b1);
    step(1'b1, 64'd3, 1'b1);
    repeat (6) step(1'b0, 64'd0, 1'b1);
    chk("post-reset output_3", output_3, 64'd7);

    // Long idle: pulses stay low, outputs hold.
    repeat (1000) step(1'b0, 64'd0, 1'b1);
    chk("idle output_3 held", output_3, 64'd7);

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
    end
    repeat (8) step(1'b0, 64'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
